// File: rtl/inst_rom_loader_pkg.sv
// Shared constants and loader state encodings for the instruction ROM loader.
package inst_rom_loader_pkg;

  localparam int          INST_MEM_NUM_LOG2 = 10;
  localparam int          INST_MEM_NUM      = 1 << INST_MEM_NUM_LOG2;
  localparam logic [31:0] ZERO_WORD         = 32'h0000_0000;
  localparam logic        CHIP_ENABLE       = 1'b1;
  localparam logic        CHIP_DISABLE      = 1'b0;

  typedef enum logic [1:0] {
    LD_LOAD  = 2'd0,
    LD_FLUSH = 2'd1,
    LD_RUN   = 2'd2
  } ld_state_e;

endpackage

// File: rtl/inst_rom_loader_if.sv
// Fetch port and loader byte stream of the instruction ROM loader.
// The master side is the core/board (PC block plus byte source); the slave side is the loader.
interface inst_rom_loader_if;
  logic        ce;
  logic [31:0] addr;
  logic [31:0] inst;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_last;
  logic        ld_ready;

  modport master (
    output ce, addr, ld_valid, ld_data, ld_last,
    input  inst, ld_ready
  );

  modport slave (
    input  ce, addr, ld_valid, ld_data, ld_last,
    output inst, ld_ready
  );
endinterface

// File: rtl/inst_rom_loader_inst_ram.sv
// Instruction memory array: one write port, one synchronous read port, no reset on the array.
module inst_ram #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [31:0]       wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [0:(1<<ADDR_W)-1];
  logic [31:0] rdata_q;

  // Write and registered read; kept free of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/inst_rom_loader.sv
// Instruction ROM loader: fills instruction memory from a byte stream, holds the
// core until the image is in, then serves word-aligned fetches with one cycle latency.
//
// state    | meaning
// ---------+------------------------------------------------------------
// LD_LOAD  | accepting bytes, packing big-endian words into memory
// LD_FLUSH | one idle cycle so the last write lands before any fetch
// LD_RUN   | core released, fetches served, loader inputs ignored
module inst_rom_loader
  import inst_rom_loader_pkg::*;
#(
  parameter int          ADDR_W   = INST_MEM_NUM_LOG2,
  parameter logic [31:0] INST_NOP = ZERO_WORD
) (
  input  logic                 clk,
  input  logic                 rst_n,
  inst_rom_loader_if.slave     bus,
  input  logic                 reload_i,
  output logic                 cpu_hold_o,
  output logic [ADDR_W:0]      words_loaded_o,
  output logic                 load_ovf_o
);

  localparam int unsigned    DEPTH_I = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH  = DEPTH_I[ADDR_W:0];

  ld_state_e         state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [31:0]       asm_q, asm_d;
  logic [31:0]       word;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic              ovf_q, ovf_d;
  logic              rdy_q;
  logic              re_q;
  logic              xfer, full, we, re, in_range;
  logic [31:0]       rdata;

  // Next-state, packer and counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    ptr_d   = ptr_q;
    words_d = words_q;
    ovf_d   = ovf_q;
    we      = 1'b0;
    xfer    = bus.ld_valid & rdy_q;
    full    = (words_q == DEPTH);

    // The assembly register is cleared after every word, so inserting the current
    // byte at its slot also zero-pads the low bytes of a short final word.
    word = asm_q;
    case (cnt_q)
      2'd0:    word[31:24] = bus.ld_data;
      2'd1:    word[23:16] = bus.ld_data;
      2'd2:    word[15:8]  = bus.ld_data;
      default: word[7:0]   = bus.ld_data;
    endcase

    case (state_q)
      LD_LOAD: begin
        if (xfer) begin
          if (full) begin
            ovf_d = 1'b1;
          end else if (cnt_q == 2'd3 || bus.ld_last) begin
            we      = 1'b1;
            ptr_d   = ptr_q + 1'b1;
            words_d = words_q + 1'b1;
            asm_d   = '0;
          end else begin
            asm_d = word;
          end
          cnt_d = cnt_q + 2'd1;
          if (bus.ld_last) begin
            state_d = LD_FLUSH;
            cnt_d   = '0;
            asm_d   = '0;
          end
        end
      end
      LD_FLUSH: state_d = LD_RUN;
      LD_RUN: begin
        if (reload_i) begin
          state_d = LD_LOAD;
          cnt_d   = '0;
          asm_d   = '0;
          ptr_d   = '0;
          words_d = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = LD_LOAD;
    endcase
  end

  assign in_range = (bus.addr[31:ADDR_W+2] == '0);
  assign re       = (bus.ce == CHIP_ENABLE) && (state_q == LD_RUN) && in_range;

  // State and datapath registers; ld_ready is registered so it stays low through reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LD_LOAD;
      cnt_q   <= '0;
      asm_q   <= '0;
      ptr_q   <= '0;
      words_q <= '0;
      ovf_q   <= 1'b0;
      rdy_q   <= 1'b0;
      re_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      ptr_q   <= ptr_d;
      words_q <= words_d;
      ovf_q   <= ovf_d;
      rdy_q   <= (state_d == LD_LOAD);
      re_q    <= re;
    end
  end

  inst_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (ptr_q),
    .wdata_i (word),
    .re_i    (re),
    .raddr_i (bus.addr[ADDR_W+1:2]),
    .rdata_o (rdata)
  );

  assign bus.ld_ready    = rdy_q;
  assign bus.inst        = re_q ? rdata : INST_NOP;
  assign cpu_hold_o      = (state_q != LD_RUN);
  assign words_loaded_o  = words_q;
  assign load_ovf_o      = ovf_q;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed bench for the instruction ROM loader: a full-size instance and a
// four-word instance for the overflow case.
module tb_inst_rom_loader;

  logic        clk = 1'b0;
  logic        rst_na = 1'b1;
  logic        rst_nb = 1'b1;
  logic        reload_a = 1'b0;
  logic        reload_b = 1'b0;
  logic        hold_a, hold_b;
  logic        ovf_a, ovf_b;
  logic [10:0] words_a;
  logic [2:0]  words_b;
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  inst_rom_loader_if bus_a ();
  inst_rom_loader_if bus_b ();

  inst_rom_loader #(.ADDR_W(10)) u_a (
    .clk            (clk),
    .rst_n          (rst_na),
    .bus            (bus_a.slave),
    .reload_i       (reload_a),
    .cpu_hold_o     (hold_a),
    .words_loaded_o (words_a),
    .load_ovf_o     (ovf_a)
  );

  inst_rom_loader #(.ADDR_W(2)) u_b (
    .clk            (clk),
    .rst_n          (rst_nb),
    .bus            (bus_b.slave),
    .reload_i       (reload_b),
    .cpu_hold_o     (hold_b),
    .words_loaded_o (words_b),
    .load_ovf_o     (ovf_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h want %08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input bit sel, input logic [7:0] d, input bit last);
    @(negedge clk);
    if (sel) begin
      bus_b.ld_valid = 1'b1; bus_b.ld_data = d; bus_b.ld_last = last;
    end else begin
      bus_a.ld_valid = 1'b1; bus_a.ld_data = d; bus_a.ld_last = last;
    end
    @(posedge clk);
    #1;
    bus_a.ld_valid = 1'b0; bus_a.ld_last = 1'b0;
    bus_b.ld_valid = 1'b0; bus_b.ld_last = 1'b0;
  endtask

  task automatic fetch(input bit sel, input logic ce, input logic [31:0] a);
    @(negedge clk);
    if (sel) begin
      bus_b.ce = ce; bus_b.addr = a;
    end else begin
      bus_a.ce = ce; bus_a.addr = a;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reload_a();
    @(negedge clk);
    reload_a = 1'b1;
    @(posedge clk);
    #1;
    reload_a = 1'b0;
  endtask

  logic [7:0] img1 [0:7] = '{8'h3C, 8'h01, 8'h12, 8'h34, 8'h34, 8'h21, 8'h56, 8'h78};
  logic [7:0] img2 [0:4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
  logic [7:0] img3 [0:3] = '{8'h55, 8'h66, 8'h77, 8'h88};

  initial begin
    bus_a.ce = 1'b0; bus_a.addr = '0; bus_a.ld_valid = 1'b0; bus_a.ld_data = '0; bus_a.ld_last = 1'b0;
    bus_b.ce = 1'b0; bus_b.addr = '0; bus_b.ld_valid = 1'b0; bus_b.ld_data = '0; bus_b.ld_last = 1'b0;

    // Reset values
    #3;
    rst_na = 1'b0;
    rst_nb = 1'b0;
    #2;
    chk("rst_inst",  bus_a.inst, 32'h0);
    chk("rst_hold",  32'(hold_a), 32'h1);
    chk("rst_ready", 32'(bus_a.ld_ready), 32'h0);
    chk("rst_words", 32'(words_a), 32'h0);
    chk("rst_ovf",   32'(ovf_a), 32'h0);
    @(negedge clk);
    rst_na = 1'b1;
    rst_nb = 1'b1;
    #1;
    chk("ready_before_edge", 32'(bus_a.ld_ready), 32'h0);
    tick(1);
    chk("ready_after_edge", 32'(bus_a.ld_ready), 32'h1);

    // Eight-byte image
    for (int i = 0; i < 8; i++) push(1'b0, img1[i], i == 7);
    chk("img1_words", 32'(words_a), 32'd2);
    chk("img1_flush_hold", 32'(hold_a), 32'h1);
    chk("img1_flush_ready", 32'(bus_a.ld_ready), 32'h0);
    tick(1);
    chk("img1_run_hold", 32'(hold_a), 32'h0);

    fetch(1'b0, 1'b1, 32'h0);
    chk("fetch_w0", bus_a.inst, 32'h3C01_1234);
    fetch(1'b0, 1'b1, 32'h4);
    chk("fetch_w1", bus_a.inst, 32'h3421_5678);
    fetch(1'b0, 1'b1, 32'h7);
    chk("fetch_unaligned", bus_a.inst, 32'h3421_5678);
    fetch(1'b0, 1'b0, 32'h0);
    chk("fetch_ce0", bus_a.inst, 32'h0);
    fetch(1'b0, 1'b1, 32'h0000_1000);
    chk("fetch_oor", bus_a.inst, 32'h0);

    // Reload and short final word
    pulse_reload_a();
    chk("reload_hold",  32'(hold_a), 32'h1);
    chk("reload_words", 32'(words_a), 32'h0);
    chk("reload_ready", 32'(bus_a.ld_ready), 32'h1);
    fetch(1'b0, 1'b1, 32'h0);
    chk("reload_fetch_nop", bus_a.inst, 32'h0);
    for (int i = 0; i < 5; i++) push(1'b0, img2[i], i == 4);
    chk("img2_words", 32'(words_a), 32'd2);
    tick(1);
    fetch(1'b0, 1'b1, 32'h0);
    chk("img2_w0", bus_a.inst, 32'hAABB_CCDD);
    fetch(1'b0, 1'b1, 32'h4);
    chk("img2_w1_pad", bus_a.inst, 32'hEE00_0000);

    // Reset mid-word
    pulse_reload_a();
    push(1'b0, 8'h11, 1'b0);
    push(1'b0, 8'h22, 1'b0);
    #2;
    rst_na = 1'b0;
    #1;
    chk("midrst_hold",  32'(hold_a), 32'h1);
    chk("midrst_ready", 32'(bus_a.ld_ready), 32'h0);
    chk("midrst_words", 32'(words_a), 32'h0);
    chk("midrst_inst",  bus_a.inst, 32'h0);
    @(negedge clk);
    rst_na = 1'b1;
    tick(1);
    for (int i = 0; i < 4; i++) push(1'b0, img3[i], i == 3);
    chk("img3_words", 32'(words_a), 32'd1);
    tick(1);
    fetch(1'b0, 1'b1, 32'h0);
    chk("img3_w0_realigned", bus_a.inst, 32'h5566_7788);
    fetch(1'b0, 1'b1, 32'h4);
    chk("img3_w1_retained", bus_a.inst, 32'hEE00_0000);

    // Overflow on the four-word instance
    for (int i = 0; i < 20; i++) begin
      push(1'b1, 8'(8'h10 + i), i == 19);
      if (i == 15) begin
        chk("ovf_full_words", 32'(words_b), 32'd4);
        chk("ovf_not_yet",    32'(ovf_b), 32'h0);
      end
      if (i == 16) chk("ovf_set", 32'(ovf_b), 32'h1);
    end
    chk("ovf_words_sat", 32'(words_b), 32'd4);
    chk("ovf_sticky",    32'(ovf_b), 32'h1);
    tick(1);
    chk("ovf_run_hold", 32'(hold_b), 32'h0);
    fetch(1'b1, 1'b1, 32'h0);
    chk("ovf_w0", bus_b.inst, 32'h1011_1213);
    fetch(1'b1, 1'b1, 32'h4);
    chk("ovf_w1", bus_b.inst, 32'h1415_1617);
    fetch(1'b1, 1'b1, 32'h8);
    chk("ovf_w2", bus_b.inst, 32'h1819_1A1B);
    fetch(1'b1, 1'b1, 32'hC);
    chk("ovf_w3", bus_b.inst, 32'h1C1D_1E1F);
    fetch(1'b1, 1'b1, 32'h10);
    chk("ovf_oor", bus_b.inst, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
